// File: rtl/mips_fetch_queue_if.sv
// Fetch-stage handshake bundle: imem request/response, decode output, redirect.
// Latency: none (wires only).
// Backpressure: valid/ready on imem request and decode output; responses and redirects have no backpressure.
interface mips_fetch_queue_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    // Fetch block side
    modport master (
        output imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc,
        input  imem_req_ready, imem_resp_valid, imem_resp_data, inst_ready,
               redirect_valid, redirect_pc
    );

    // Memory / decode side
    modport slave (
        input  imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc,
        output imem_req_ready, imem_resp_valid, imem_resp_data, inst_ready,
               redirect_valid, redirect_pc
    );
endinterface

// File: rtl/mips_fetch_queue.sv
// Sequential instruction fetch with a DEPTH-entry in-order response queue feeding decode.
// Latency: request in cycle 0, response in cycle N, inst_valid in cycle N+1 (no bypass).
// Backpressure: requests stop when allocated entries plus stale in-flight responses reach DEPTH.
module mips_fetch_queue #(
    parameter logic [31:0] RESET_PC = 32'h0010_0000,
    parameter int          DEPTH    = 4
) (
    input  logic              clk,
    input  logic              reset,
    mips_fetch_queue_if.master fq
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    typedef logic [PW-1:0] ptr_t;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    // Entries in [head, fill) are filled, [fill, tail) are waiting on memory.
    logic [31:0] fetch_pc_q, fetch_pc_d;
    ptr_t        head_q, head_d;
    ptr_t        fill_q, fill_d;
    ptr_t        tail_q, tail_d;
    ptr_t        drop_q, drop_d;
    logic [31:0] pc_mem_q   [DEPTH];
    logic [31:0] pc_mem_d   [DEPTH];
    logic [31:0] data_mem_q [DEPTH];
    logic [31:0] data_mem_d [DEPTH];

    ptr_t        count;
    ptr_t        unfilled;
    logic [PW:0] credit_used;
    logic        accept;
    logic        pop;
    logic        resp_drop;
    logic        resp_fill;
    logic        resp_any;

    assign count       = tail_q - head_q;
    assign unfilled    = tail_q - fill_q;
    assign credit_used = {1'b0, count} + {1'b0, drop_q};

    assign fq.imem_req_valid = ~reset & (credit_used < (PW+1)'(DEPTH));
    assign fq.imem_req_addr  = fetch_pc_q;
    assign fq.inst_valid     = (fill_q != head_q);
    assign fq.inst_pc        = pc_mem_q[head_q[AW-1:0]];
    assign fq.inst_data      = data_mem_q[head_q[AW-1:0]];

    assign accept    = fq.imem_req_valid & fq.imem_req_ready;
    assign pop       = fq.inst_valid & fq.inst_ready;
    assign resp_drop = fq.imem_resp_valid & (drop_q != '0);
    assign resp_fill = fq.imem_resp_valid & (drop_q == '0) & (fill_q != tail_q);
    assign resp_any  = resp_drop | resp_fill;

    // Next-state for pointers, stale-response count and fetch PC; redirect overrides everything.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        head_d     = head_q;
        fill_d     = fill_q;
        tail_d     = tail_q;
        drop_d     = drop_q;
        if (fq.redirect_valid) begin
            // Every unfilled entry plus this cycle's accepted request becomes stale;
            // a response arriving now is already accounted for by consuming one of them.
            head_d     = tail_q;
            fill_d     = tail_q;
            tail_d     = tail_q;
            drop_d     = drop_q + unfilled + {{AW{1'b0}}, accept} - {{AW{1'b0}}, resp_any};
            fetch_pc_d = {fq.redirect_pc[31:2], 2'b00};
        end else begin
            if (accept) begin
                tail_d     = tail_q + 1'b1;
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
            if (resp_fill) fill_d = fill_q + 1'b1;
            if (pop)       head_d = head_q + 1'b1;
            if (resp_drop) drop_d = drop_q - 1'b1;
        end
    end

    // Entry payload writes: PC at allocation, instruction word at fill.
    always_comb begin
        pc_mem_d   = pc_mem_q;
        data_mem_d = data_mem_q;
        if (accept)    pc_mem_d[tail_q[AW-1:0]]   = fetch_pc_q;
        if (resp_fill) data_mem_d[fill_q[AW-1:0]] = fq.imem_resp_data;
    end

    // Control state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q <= RESET_PC;
            head_q     <= '0;
            fill_q     <= '0;
            tail_q     <= '0;
            drop_q     <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            head_q     <= head_d;
            fill_q     <= fill_d;
            tail_q     <= tail_d;
            drop_q     <= drop_d;
        end
    end

    // Payload storage; contents are only observed behind valid pointers, so no reset.
    always_ff @(posedge clk) begin
        pc_mem_q   <= pc_mem_d;
        data_mem_q <= data_mem_d;
    end

    // A response with nothing waiting for it means the memory broke the one-per-request rule.
    a_resp_expected: assert property (@(posedge clk) disable iff (reset)
        fq.imem_resp_valid |-> ((drop_q != '0) || (fill_q != tail_q)));

endmodule

// File: tb/tb_mips_fetch_queue.sv
// Bench for mips_fetch_queue: variable-latency memory, queue-based reference model, directed scenarios.
// Latency: memory answers each accepted request exactly lat cycles later.
// Backpressure: decode readiness and memory readiness are driven per scenario.
module tb_mips_fetch_queue;
    localparam logic [31:0] RESET_PC = 32'h0010_0000;
    localparam int          DEPTH    = 4;

    logic clk;
    logic reset;
    mips_fetch_queue_if bus();

    mips_fetch_queue #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .fq    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: list of outstanding fetches in program order.
    typedef struct packed {
        logic [31:0] pc;
        logic        stale;
        logic        ret;
    } ent_t;
    ent_t        mq[$];
    logic [31:0] m_pc;
    logic [31:0] stream_pc;
    logic [31:0] popped[$];

    // Memory delay line indexed by absolute cycle
    int          lat;
    int          cyc;
    logic        mv[8];
    logic [31:0] ma[8];
    int          n_acc;
    logic [31:0] last_acc;

    // Per-cycle snapshot of DUT outputs for directed checks
    logic        s_req_v, s_inst_v, s_resp_v;
    logic [31:0] s_req_a, s_inst_pc, s_inst_dat, s_resp_a;

    function automatic logic [31:0] mem_f(input logic [31:0] a);
        return a ^ 32'hA5A5_5A5A;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic chk1(input string name, input logic got, input logic exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    function automatic int live_idx();
        foreach (mq[i]) if (!mq[i].stale) return i;
        return -1;
    endfunction

    function automatic int unreturned_cnt();
        int n = 0;
        foreach (mq[i]) if (!mq[i].ret) n++;
        return n;
    endfunction

    task automatic check_outputs();
        int   li;
        logic exp_req, exp_iv;
        if (reset) begin
            chk1("req_valid_in_reset", bus.imem_req_valid, 1'b0);
            return;
        end
        exp_req = (mq.size() < DEPTH);
        li      = live_idx();
        exp_iv  = (li >= 0) && mq[li].ret;
        chk1("req_valid", bus.imem_req_valid, exp_req);
        if (exp_req) begin
            chk("req_addr", bus.imem_req_addr, m_pc);
            chk("req_addr_align", {30'd0, bus.imem_req_addr[1:0]}, 32'd0);
        end
        chk1("inst_valid", bus.inst_valid, exp_iv);
        if (exp_iv) begin
            chk("inst_pc", bus.inst_pc, mq[li].pc);
            chk("inst_data", bus.inst_data, mem_f(mq[li].pc));
        end
    endtask

    task automatic model_step();
        int   li;
        logic exp_req, exp_iv, m_pop, m_acc;
        if (reset) begin
            mq.delete();
            m_pc = RESET_PC;
            return;
        end
        li      = live_idx();
        exp_iv  = (li >= 0) && mq[li].ret;
        exp_req = (mq.size() < DEPTH);
        m_pop   = exp_iv && bus.inst_ready;
        m_acc   = exp_req && bus.imem_req_ready;
        if (m_pop) mq.delete(li);
        if (bus.imem_resp_valid) begin
            int k = -1;
            foreach (mq[i]) if (k < 0 && !mq[i].ret) k = i;
            if (k < 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL resp_orphan: response with no outstanding request (cycle %0d)", cyc);
            end else if (mq[k].stale) begin
                mq.delete(k);
            end else begin
                mq[k].ret = 1'b1;
            end
        end
        if (bus.redirect_valid) begin
            ent_t keep[$];
            foreach (mq[i]) begin
                if (!mq[i].ret) begin
                    ent_t e = mq[i];
                    e.stale = 1'b1;
                    keep.push_back(e);
                end
            end
            mq = keep;
        end
        if (m_acc) begin
            mq.push_back('{pc: m_pc, stale: bus.redirect_valid, ret: 1'b0});
            m_pc = m_pc + 32'd4;
        end
        if (bus.redirect_valid) m_pc = {bus.redirect_pc[31:2], 2'b00};
    endtask

    // One clock cycle: inputs are already set by the caller at the falling edge.
    task automatic cycle();
        int slot;
        slot = cyc % 8;
        if (reset) begin
            for (int i = 0; i < 8; i++) mv[i] = 1'b0;
        end
        bus.imem_resp_valid = mv[slot];
        bus.imem_resp_data  = mem_f(ma[slot]);
        s_resp_v = mv[slot];
        s_resp_a = ma[slot];
        mv[slot] = 1'b0;
        #1;
        check_outputs();
        s_req_v    = bus.imem_req_valid;
        s_req_a    = bus.imem_req_addr;
        s_inst_v   = bus.inst_valid;
        s_inst_pc  = bus.inst_pc;
        s_inst_dat = bus.inst_data;
        if (reset) begin
            stream_pc = RESET_PC;
        end else begin
            if (bus.inst_valid && bus.inst_ready) begin
                chk("stream_pc", bus.inst_pc, stream_pc);
                popped.push_back(bus.inst_pc);
                stream_pc = stream_pc + 32'd4;
            end
            if (bus.redirect_valid) stream_pc = {bus.redirect_pc[31:2], 2'b00};
        end
        model_step();
        if (!reset && bus.imem_req_valid && bus.imem_req_ready) begin
            mv[(cyc + lat) % 8] = 1'b1;
            ma[(cyc + lat) % 8] = bus.imem_req_addr;
            n_acc++;
            last_acc = bus.imem_req_addr;
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic do_reset(input int new_lat);
        reset = 1'b1;
        bus.redirect_valid = 1'b0;
        lat = new_lat;
        repeat (2) cycle();
        reset = 1'b0;
        n_acc = 0;
        popped.delete();
    endtask

    initial begin
        int   pb, n_stale, n_seen, found, unf;
        reset              = 1'b1;
        lat                = 1;
        cyc                = 0;
        n_acc              = 0;
        last_acc           = '0;
        m_pc               = RESET_PC;
        stream_pc          = RESET_PC;
        bus.imem_req_ready = 1'b0;
        bus.inst_ready     = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.imem_resp_valid = 1'b0;
        bus.imem_resp_data = '0;
        for (int i = 0; i < 8; i++) begin mv[i] = 1'b0; ma[i] = '0; end
        @(negedge clk);

        // Reset state and single-cycle memory streaming
        bus.imem_req_ready = 1'b1;
        bus.inst_ready     = 1'b1;
        do_reset(1);
        cycle();
        chk1("t1_c0_req_valid", s_req_v, 1'b1);
        chk("t1_c0_req_addr", s_req_a, 32'h0010_0000);
        chk1("t1_c0_inst_valid", s_inst_v, 1'b0);
        cycle();
        chk1("t1_c1_inst_valid", s_inst_v, 1'b0);
        cycle();
        chk1("t1_c2_inst_valid", s_inst_v, 1'b1);
        chk("t1_c2_inst_pc", s_inst_pc, 32'h0010_0000);
        chk("t1_c2_inst_data", s_inst_dat, 32'hA5B5_5A5A);
        repeat (10) cycle();
        chk("t1_pop_count", 32'(popped.size()), 32'd11);
        if (popped.size() > 0) chk("t1_last_pc", popped[popped.size()-1], 32'h0010_0028);

        // Decode stalled: queue fills to DEPTH, one pop frees one credit
        bus.inst_ready = 1'b0;
        do_reset(1);
        repeat (8) cycle();
        chk("t2_accepts", 32'(n_acc), 32'd4);
        chk("t2_last_acc", last_acc, 32'h0010_000C);
        chk1("t2_full_req_valid", s_req_v, 1'b0);
        bus.inst_ready = 1'b1;
        cycle();
        chk("t2_pop_pc", s_inst_pc, 32'h0010_0000);
        bus.inst_ready = 1'b0;
        cycle();
        chk1("t2_after_pop_req_valid", s_req_v, 1'b1);
        chk("t2_after_pop_req_addr", s_req_a, 32'h0010_0010);

        // 3-cycle memory, redirect with two requests in flight
        bus.inst_ready = 1'b1;
        do_reset(3);
        cycle();
        cycle();
        bus.imem_req_ready = 1'b0;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0010_0400;
        cycle();
        bus.redirect_valid = 1'b0;
        bus.imem_req_ready = 1'b1;
        cycle();
        chk1("t3_req_valid", s_req_v, 1'b1);
        chk("t3_req_addr", s_req_a, 32'h0010_0400);
        repeat (12) cycle();
        chk1("t3_have_pops", popped.size() > 0, 1'b1);
        if (popped.size() > 0) chk("t3_first_pc", popped[0], 32'h0010_0400);
        n_stale = 0;
        foreach (popped[i]) if (popped[i] < 32'h0010_0400) n_stale++;
        chk("t3_stale_pops", 32'(n_stale), 32'd0);

        // Redirect, acceptance and response all in one cycle
        do_reset(3);
        found = 0;
        for (int k = 0; k < 20 && found == 0; k++) begin
            if (k >= 4 && mq.size() < DEPTH && mv[cyc % 8]) found = 1;
            else cycle();
        end
        chk1("t4_found_cycle", found == 1, 1'b1);
        unf = unreturned_cnt();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0020_0000;
        cycle();
        bus.redirect_valid = 1'b0;
        pb      = popped.size();
        n_stale = 0;
        n_seen  = 0;
        for (int k = 0; k < 15; k++) begin
            cycle();
            if (s_resp_v) begin
                n_seen++;
                if (s_resp_a < 32'h0020_0000) n_stale++;
            end
        end
        chk("t4_dropped", 32'(n_stale), 32'(unf));
        chk1("t4_have_pops", popped.size() > pb, 1'b1);
        if (popped.size() > pb) chk("t4_first_pc", popped[pb], 32'h0020_0000);

        // Misaligned redirect target, with a pop in the redirect cycle
        do_reset(1);
        repeat (5) cycle();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0010_0402;
        cycle();
        chk1("t5_pop_in_redirect", s_inst_v, 1'b1);
        chk("t5_pop_pc", s_inst_pc, 32'h0010_000C);
        pb = popped.size();
        bus.redirect_valid = 1'b0;
        cycle();
        chk("t5_req_addr", s_req_a, 32'h0010_0400);
        repeat (6) cycle();
        chk1("t5_have_pops", popped.size() > pb, 1'b1);
        if (popped.size() > pb) chk("t5_first_pc", popped[pb], 32'h0010_0400);
        n_seen = 0;
        foreach (popped[i]) if (popped[i] == 32'h0010_000C) n_seen++;
        chk("t5_popped_once", 32'(n_seen), 32'd1);

        // Reset with three requests outstanding
        bus.inst_ready = 1'b0;
        do_reset(3);
        repeat (3) cycle();
        do_reset(3);
        cycle();
        chk("t6_first_req_addr", s_req_a, 32'h0010_0000);
        chk1("t6_c0_inst_valid", s_inst_v, 1'b0);
        for (int i = 1; i <= 3; i++) begin
            cycle();
            chk1("t6_inst_valid_low", s_inst_v, 1'b0);
        end
        cycle();
        chk1("t6_c4_inst_valid", s_inst_v, 1'b1);
        chk("t6_c4_inst_pc", s_inst_pc, 32'h0010_0000);
        repeat (4) cycle();
        chk("t6_accepts", 32'(n_acc), 32'd4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/mips_fetch_queue.md
# mips_fetch_queue

Instruction fetch stage for the simple MIPS core: generates sequential fetch addresses starting at the reset PC and issues them to instruction memory over a valid/ready request channel. It collects in-order responses into a DEPTH-entry queue and presents `{pc, instruction}` pairs to decode over a valid/ready channel. Redirects come from decode after the delay slot has been consumed; they flush the queue and discard stale in-flight responses. The block sits directly upstream of the decode/execute datapath and replaces its combinational `memory[pc]` read.

## Interface
- `RESET_PC`, 32'h0010_0000, first fetch address after reset
- `DEPTH`, 4, queue entries and maximum outstanding requests; power of 2, ≥2
- `clk  in  1  clock`
- `reset  in  1  synchronous, active-high`
- `imem_req_valid  out  1  fetch request valid`
- `imem_req_ready  in  1  memory accepts request this cycle`
- `imem_req_addr  out  32  word-aligned fetch address; bits [1:0] always 0`
- `imem_resp_valid  in  1  one response per accepted request, in order, no backpressure`
- `imem_resp_data  in  32  instruction word`
- `inst_valid  out  1  head entry holds a returned instruction`
- `inst_ready  in  1  decode consumes head this cycle`
- `inst_data  out  32  head instruction`
- `inst_pc  out  32  PC of head instruction`
- `redirect_valid  in  1  flush and restart fetch`
- `redirect_pc  in  32  new fetch PC; bits [1:0] ignored (forced 0)`

## Operation
- State: `fetch_pc` (32b); circular queue of DEPTH entries `{pc, data, filled}`; `count` (allocated entries); `drop` (stale in-flight responses to discard), both log2(DEPTH)+1 bits.
- Request: `imem_req_valid = ~reset & (count + drop < DEPTH)`; `imem_req_addr = fetch_pc`. Accept = valid & ready: allocate tail entry `{fetch_pc, –, filled=0}`, `fetch_pc += 4` (wraps mod 2^32).
- Memory samples a request only on valid & ready. The block may drop valid or change the address only on a redirect.
- Response, `drop > 0`: discard the data and decrement `drop`. Response, `drop == 0`: write the data into the oldest unfilled entry and set `filled`. A response arriving with no entry and no drop pending is ignored; a simulation assertion fires.
- Output: `inst_valid = head.filled`, with `inst_pc`/`inst_data` taken from the head. Pop on inst_valid & inst_ready.
- Redirect (highest priority):
  - Any pop in the same cycle completes; decode retired that instruction.
  - Then all entries are cleared: `count <= 0`, head = tail.
  - `drop <= drop + (unfilled entries) + accept_this_cycle - resp_this_cycle`, where the subtracted response is the one discarded this cycle.
  - `fetch_pc <= redirect_pc & ~3`.
  - The request accepted in the redirect cycle uses the old `fetch_pc` and is counted as stale.
- Delay slots are not handled here. Decode redirects only after consuming the delay slot.

## Timing
- Reset values: `imem_req_valid=0`, `inst_valid=0`, `count=0`, `drop=0`, `fetch_pc=RESET_PC`. `inst_data`/`inst_pc` are don't-care while `inst_valid=0`.
- The instruction memory model is reset in the same cycles. Responses during reset are ignored.
- Reset mid-operation discards all entries and in-flight state. The first request goes out in the first cycle with reset low, at `RESET_PC`.
- Fill latency: response in cycle N gives `inst_valid` in cycle N+1. There is no response-to-output bypass.
- Redirect in cycle N gives a request to the new PC in cycle N+1, if credit allows.
- Throughput: with single-cycle memory and `inst_ready=1`, one instruction per cycle is sustained.
- Queue full (`count + drop == DEPTH`): no request. A pop in cycle N allows a request in cycle N+1.
- All outputs are registered or derived from registered state only. There is no combinational path from `inst_ready`, `redirect_valid` or `imem_*` inputs to any output.

## Test plan
- Reset release, `imem_req_ready=1`, 1-cycle response: request to 0x00100000 in cycle 0, `inst_valid` in cycle 2. Then `inst_pc` = 0x00100000, 0x00100004, 0x00100008… one per cycle, with data matching the memory image.
- `inst_ready=0` throughout: exactly DEPTH=4 requests accepted (0x00100000–0x0010000C), then `imem_req_valid=0`. Raising `inst_ready` for one pop gives a request to 0x00100010 on the next cycle.
- 3-cycle memory latency, redirect to 0x00100400 with 2 requests in flight: both stale responses are discarded. The first `inst_pc` after the redirect is 0x00100400 and no stale PC ever appears.
- Same cycle: redirect, a request acceptance and a stale response. Expect `drop` = prior unfilled + 1 - 1; exactly that many later responses are dropped and the next output is the redirect target.
- `redirect_pc=0x00100402` → `imem_req_addr=0x00100400`. Redirect with `inst_valid & inst_ready` in the same cycle: the popped instruction is counted once and the old head is not re-presented.
- Assert reset with 3 requests outstanding, release: `inst_valid` stays low until a fresh fill, the first request is 0x00100000, and `count=drop=0` after reset.
